// File: rtl/keyboard_keymap.sv
// PS/2 keyboard receiver with set-2 scancode decoding into per-key held/press state.
module keyboard_keymap #(
  parameter int unsigned          N_KEYS         = 3,
  parameter logic [N_KEYS*9-1:0]  KEY_CODES      = {9'h174, 9'h16B, 9'h029},
  parameter int unsigned          FILTER_LEN     = 8,
  parameter int unsigned          TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [N_KEYS-1:0] key_held,
  output logic [N_KEYS-1:0] key_press,
  output logic [7:0]        code,
  output logic              code_valid,
  output logic              frame_err
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic           clk_s1, clk_s2, data_s1, data_s2;
  logic           filt, filt_d;
  logic [FCW-1:0] fcnt;
  logic           fall;

  state_t         state, state_n;
  logic [2:0]     bit_cnt, bit_cnt_n;
  logic [7:0]     shift, shift_n;
  logic           par, par_n;
  logic [TCW-1:0] tmo, tmo_n;
  logic           accept_c, err_c;

  logic              ext, brk, ext_n, brk_n;
  logic [N_KEYS-1:0] held_n, press_n;
  logic [7:0]        code_n;

  // Two-flop synchronisers; clock path resets to the idle-high bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Glitch filter: level follows only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
        filt <= clk_s2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FCW'(1);
      end
    end
  end

  assign fall = filt_d & ~filt;

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tmo     <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par     <= par_n;
      tmo     <= tmo_n;
    end
  end

  // Frame next-state: start/data/parity/stop sequencing plus idle timeout.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    tmo_n     = tmo;
    accept_c  = 1'b0;
    err_c     = 1'b0;

    if (state == IDLE || fall) begin
      tmo_n = '0;
    end else begin
      tmo_n = tmo + TCW'(1);
    end

    unique case (state)
      IDLE: begin
        if (fall && !data_s2) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_n   = {data_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = data_s2;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if ((^{shift, par}) && data_s2) accept_c = 1'b1;
          else                            err_c    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && !fall && tmo == TCW'(TIMEOUT_CYCLES - 1)) begin
      state_n  = IDLE;
      tmo_n    = '0;
      accept_c = 1'b0;
      err_c    = 1'b1;
    end
  end

  // Scancode decoder: prefix flags, then table lookup of {ext, byte}.
  always_comb begin
    held_n  = key_held;
    press_n = '0;
    ext_n   = ext;
    brk_n   = brk;
    code_n  = code;

    if (err_c) begin
      ext_n = 1'b0;
      brk_n = 1'b0;
    end else if (accept_c) begin
      code_n = shift;
      if (shift == 8'hE0) begin
        ext_n = 1'b1;
      end else if (shift == 8'hF0) begin
        brk_n = 1'b1;
      end else begin
        for (int i = 0; i < int'(N_KEYS); i++) begin
          if ({ext, shift} == KEY_CODES[i*9 +: 9]) begin
            if (brk) begin
              held_n[i] = 1'b0;
            end else begin
              held_n[i]  = 1'b1;
              press_n[i] = ~key_held[i];
            end
          end
        end
        ext_n = 1'b0;
        brk_n = 1'b0;
      end
    end
  end

  // Registered decoder outputs and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_held   <= '0;
      key_press  <= '0;
      code       <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
    end else begin
      key_held   <= held_n;
      key_press  <= press_n;
      code       <= code_n;
      code_valid <= accept_c;
      frame_err  <= err_c;
      ext        <= ext_n;
      brk        <= brk_n;
    end
  end

endmodule

// File: tb/tb_keyboard_keymap.sv
// Directed bench for keyboard_keymap: table of frames plus timeout, glitch and reset sequences.
module tb_keyboard_keymap;

  localparam int H   = 50;    // PS/2 half period in clk cycles
  localparam int TMO = 2000;  // shortened idle timeout for simulation

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk, ps2_data;
  logic [2:0] key_held, key_press;
  logic [7:0] code;
  logic       code_valid, frame_err;

  keyboard_keymap #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_held(key_held), .key_press(key_press), .code(code),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitor, sampled on the inactive edge.
  int         valid_cnt, err_cnt, press_cycles, align_viol;
  logic [2:0] press_or, prev_held;
  initial begin
    valid_cnt = 0; err_cnt = 0; press_cycles = 0; align_viol = 0;
    press_or = '0; prev_held = '0;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (code_valid) valid_cnt++;
      if (frame_err) err_cnt++;
      if (key_press != 3'b000) press_cycles++;
      press_or = press_or | key_press;
      if (key_press != 3'b000 && !code_valid) align_viol++;
      if (key_held != prev_held && !code_valid) align_viol++;
    end
    prev_held = key_held;
  end

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       stop;
    int         exp_valid;
    int         exp_err;
    logic [2:0] exp_held;
    logic [2:0] exp_press;
    logic [7:0] exp_code;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] b, logic bp, logic st, int ev, int ee,
                              logic [2:0] eh, logic [2:0] ep, logic [7:0] ec);
    vec_t v;
    v.b = b; v.bad_par = bp; v.stop = st; v.exp_valid = ev; v.exp_err = ee;
    v.exp_held = eh; v.exp_press = ep; v.exp_code = ec;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    valid_cnt = 0; err_cnt = 0; press_cycles = 0; press_or = '0;
  endtask

  task automatic send_bit(input logic v, input logic glitch);
    ps2_data = v;
    if (glitch) begin
      repeat (20) @(posedge clk);
      ps2_clk = 1'b0; repeat (5) @(posedge clk); ps2_clk = 1'b1;
      repeat (H - 25) @(posedge clk);
    end else begin
      repeat (H) @(posedge clk);
    end
    ps2_clk = 1'b0;
    if (glitch) begin
      repeat (20) @(posedge clk);
      ps2_clk = 1'b1; repeat (5) @(posedge clk); ps2_clk = 1'b0;
      repeat (H - 25) @(posedge clk);
    end else begin
      repeat (H) @(posedge clk);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input logic glitch);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0, glitch);
    for (int k = 0; k < 8; k++) send_bit(b[k], glitch);
    send_bit(p, glitch);
    send_bit(stop, glitch);
    ps2_data = 1'b1;
    repeat (60) @(posedge clk);
  endtask

  task automatic check_frame(input string tag, input int ev, input int ee,
                             input logic [2:0] eh, input logic [2:0] ep, input logic [7:0] ec);
    @(negedge clk);
    check({tag, " code_valid pulses"}, valid_cnt, ev);
    check({tag, " frame_err pulses"}, err_cnt, ee);
    check({tag, " key_held"}, int'(key_held), int'(eh));
    check({tag, " key_press"}, int'(press_or), int'(ep));
    check({tag, " key_press cycles"}, press_cycles, (ep != 3'b000) ? 1 : 0);
    check({tag, " code"}, int'(code), int'(ec));
  endtask

  initial begin
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;

    // key0 = 29, key1 = E0 6B, key2 = E0 74
    vecs.push_back(mk(8'h29, 0, 1, 1, 0, 3'b001, 3'b001, 8'h29));
    vecs.push_back(mk(8'h29, 0, 1, 1, 0, 3'b001, 3'b000, 8'h29));
    vecs.push_back(mk(8'hE0, 0, 1, 1, 0, 3'b001, 3'b000, 8'hE0));
    vecs.push_back(mk(8'h6B, 0, 1, 1, 0, 3'b011, 3'b010, 8'h6B));
    vecs.push_back(mk(8'hE0, 0, 1, 1, 0, 3'b011, 3'b000, 8'hE0));
    vecs.push_back(mk(8'h74, 0, 1, 1, 0, 3'b111, 3'b100, 8'h74));
    vecs.push_back(mk(8'hE0, 0, 1, 1, 0, 3'b111, 3'b000, 8'hE0));
    vecs.push_back(mk(8'hF0, 0, 1, 1, 0, 3'b111, 3'b000, 8'hF0));
    vecs.push_back(mk(8'h6B, 0, 1, 1, 0, 3'b101, 3'b000, 8'h6B));
    vecs.push_back(mk(8'hF0, 0, 1, 1, 0, 3'b101, 3'b000, 8'hF0));
    vecs.push_back(mk(8'h29, 0, 1, 1, 0, 3'b100, 3'b000, 8'h29));
    vecs.push_back(mk(8'h74, 1, 1, 0, 1, 3'b100, 3'b000, 8'h29));
    vecs.push_back(mk(8'h29, 0, 0, 0, 1, 3'b100, 3'b000, 8'h29));
    vecs.push_back(mk(8'hE0, 0, 1, 1, 0, 3'b100, 3'b000, 8'hE0));
    vecs.push_back(mk(8'h11, 1, 1, 0, 1, 3'b100, 3'b000, 8'hE0));
    vecs.push_back(mk(8'h74, 0, 1, 1, 0, 3'b100, 3'b000, 8'h74));
    vecs.push_back(mk(8'hAA, 0, 1, 1, 0, 3'b100, 3'b000, 8'hAA));
    vecs.push_back(mk(8'hFA, 0, 1, 1, 0, 3'b100, 3'b000, 8'hFA));
    vecs.push_back(mk(8'hE0, 0, 1, 1, 0, 3'b100, 3'b000, 8'hE0));
    vecs.push_back(mk(8'hF0, 0, 1, 1, 0, 3'b100, 3'b000, 8'hF0));
    vecs.push_back(mk(8'h74, 0, 1, 1, 0, 3'b000, 3'b000, 8'h74));
    vecs.push_back(mk(8'h6B, 0, 1, 1, 0, 3'b000, 3'b000, 8'h6B));

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("reset key_held", int'(key_held), 0);
    check("reset key_press", int'(key_press), 0);
    check("reset code", int'(code), 0);
    check("reset code_valid", int'(code_valid), 0);
    check("reset frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      clear_mon();
      send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].stop, 1'b0);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_err,
                  vecs[i].exp_held, vecs[i].exp_press, vecs[i].exp_code);
    end

    // Glitched clock during a full frame still yields the byte.
    clear_mon();
    send_frame(8'h29, 1'b0, 1'b1, 1'b1);
    check_frame("glitch", 1, 0, 3'b001, 3'b001, 8'h29);

    // Start plus four data bits, then silence past the timeout.
    clear_mon();
    send_bit(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (TMO + 100) @(posedge clk);
    check_frame("timeout", 0, 1, 3'b001, 3'b000, 8'h29);
    clear_mon();
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check_frame("after_timeout", 1, 0, 3'b001, 3'b000, 8'h29);

    // Reset in the middle of a frame while key0 is held.
    clear_mon();
    send_bit(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset key_held", int'(key_held), 0);
    check("midreset code", int'(code), 0);
    rst_n = 1'b1;
    ps2_data = 1'b1;
    repeat (300) @(posedge clk);
    check_frame("post_reset_idle", 0, 0, 3'b000, 3'b000, 8'h00);
    clear_mon();
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check_frame("post_reset_frame", 1, 0, 3'b001, 3'b001, 8'h29);

    check("pulse alignment violations", align_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keyboard_keymap.md
KEYBOARD_KEYMAP -- requirements
Module: keyboard_keymap

Parameters
REQ-001 N_KEYS, default 3: number of tracked keys; valid range is 1 to 16.
REQ-002 KEY_CODES, default {9'h174, 9'h16B, 9'h029}: packed N_KEYS x 9-bit table; bit 8 = E0-extended flag, bits 7:0 = set-2 scancode; entry i maps to key i.
REQ-003 FILTER_LEN, default 8: consecutive equal samples required before the filtered ps2_clk changes level.
REQ-004 TIMEOUT_CYCLES, default 100000: idle clk cycles that abort a partial frame.

Interface
REQ-005 clk  in  1  system clock; all logic in this single domain.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 ps2_clk  in  1  raw PS/2 clock, asynchronous.
REQ-008 ps2_data  in  1  raw PS/2 data, asynchronous.
REQ-009 key_held  out  N_KEYS  level; bit i = key i currently down.
REQ-010 key_press  out  N_KEYS  1-cycle pulse on key i make while not already held.
REQ-011 code  out  8  last accepted byte.
REQ-012 code_valid  out  1  1-cycle pulse when code updates.
REQ-013 frame_err  out  1  1-cycle pulse on parity/stop/timeout error.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass a 2-FF synchroniser; ps2_clk then passes a FILTER_LEN-sample glitch filter.
REQ-015 A falling edge of the filtered clock SHALL sample synchronised ps2_data.
REQ-016 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: sampled 0 -> DATA with bit count cleared; sampled 1 -> ignored, stay IDLE, no error.
REQ-018 DATA: shift 8 bits LSB-first, then -> PARITY.
REQ-019 PARITY: store bit, -> STOP.
REQ-020 STOP: odd parity correct and stop = 1 -> byte accepted; otherwise frame_err pulse and byte discarded; both cases -> IDLE.
REQ-021 In any non-IDLE state, TIMEOUT_CYCLES clk cycles without a falling edge SHALL force IDLE, pulse frame_err, discard partial data.
REQ-022 Accepted byte: code and code_valid update on the clk cycle after the STOP sampling edge.
REQ-023 Decoder flags ext and brk are both 0 after reset.
REQ-024 Byte 8'hE0 sets ext; byte 8'hF0 sets brk; neither updates keys.
REQ-025 Any other byte is looked up as {ext, byte} against every KEY_CODES entry; afterwards ext and brk both clear.
REQ-026 Match with brk=0 (make): key_held[i] <= 1; key_press[i] pulses only if key_held[i] was 0, so typematic repeats give no pulse.
REQ-027 Match with brk=1 (break): key_held[i] <= 0; no pulse.
REQ-028 Duplicate table entries SHALL all update; unmatched bytes (e.g. 8'hAA, 8'hFA) only clear the flags.
REQ-029 key_held and key_press SHALL change in the same cycle as code_valid.
REQ-030 Any frame_err SHALL clear ext and brk; key_held is unchanged.
REQ-031 Independent keys SHALL be held simultaneously, with no rollover limit up to N_KEYS.

Reset
REQ-032 Asserting rst_n low SHALL immediately set: key_held=0, key_press=0, code=8'h00, code_valid=0, frame_err=0, FSM=IDLE, ext=brk=0, filter/synchroniser/timeout state cleared.
REQ-033 Reset asserted mid-frame SHALL discard the frame; after release the next start bit begins a new frame.

Verification (default parameters, 100 MHz clk, 12.5 kHz PS/2)
REQ-034 Frame 8'h29 (make) -> code=8'h29, code_valid one pulse, key_press=3'b001 for one cycle, key_held=3'b001.
REQ-035 Frames E0,6B; E0,74; then E0,F0,6B -> key_held goes 010, 110, then 100; key_press pulses 010, then 100.
REQ-036 8'h29 sent twice without a break -> exactly one key_press[0] pulse; key_held[0] stays 1.
REQ-037 Frame with wrong parity, then a frame with stop=0 -> two frame_err pulses; no code_valid; key_held unchanged.
REQ-038 Start bit plus 4 data bits, then silence for 100000 cycles -> frame_err pulse; a following valid 8'h29 decodes correctly.
REQ-039 Glitches of at most 5 cycles on ps2_clk during a frame are ignored, giving a correct byte; rst_n low mid-frame with space held -> key_held=0, and the partial frame is not decoded.
